inv_cipher_pipe: RTL and testbench
==================================

// Module: inv_cipher_pipe
// PURPOSE
//  AES-128 inverse cipher: the decrypt-side counterpart of the encrypt datapath.
//  Four-stage ring pipeline (InvShiftRows -> InvSubBytes -> AddRoundKey+InvKeyGen -> InvMixColumns).
//  Up to 4 independent ciphertext/key pairs are in flight at once, one per ring slot.
//  Round keys are derived on the fly from the supplied round-10 (final) key.
//  Plaintext leaves with the tag it entered with.
// PARAMETERS
//  TAG_W      2  width of the caller tag carried with each block
//  ZERO_IDLE  1  1 = data/key regs of empty slots forced to 0 (no residue of key/state)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  flush      in   1      synchronous: discard all in-flight slots
//  in_valid   in   1      ciphertext/key pair offered
//  in_ready   out  1      slot free at ring entry this cycle
//  in_data    in   128    ciphertext, byte 0 = [127:120]
//  in_key     in   128    AES-128 round-10 key (last expanded round key)
//  in_tag     in   TAG_W  caller id, returned unchanged
//  out_valid  out  1      plaintext valid, single-cycle pulse, no back-pressure
//  out_data   out  128    plaintext; 0 when out_valid=0
//  out_tag    out  TAG_W  tag of out_data; 0 when out_valid=0
//  busy       out  1      any slot valid
// BEHAVIOUR
//  - Reset: every slot valid=0, rnd=0, state/key/tag=0; out_valid=0, out_data=0, out_tag=0, busy=0, in_ready=1.
//  - Slot = {valid, rnd[3:0], state[127:0], key[127:0], tag}.
//  - Ring advances every cycle: s1<-entry mux, s2<-s1, s3<-s2, s4<-s3.
//  - Stage functions:
//      s1 InvShiftRows
//      s2 InvSubBytes
//      s3 k=inv_gen_rnd_key(key,rnd+1), then state^=k, key<=k
//      s4 InvMixColumns, bypassed when rnd==0
//  - Entry mux into s1, evaluated in priority order:
//      1. flush -> empty slot
//      2. s4.valid && s4.rnd!=0 -> feedback s4 with rnd-1
//      3. in_valid && in_ready -> {1, 9, in_data^in_key, in_key, in_tag}
//      4. otherwise -> empty slot
//  - in_ready = !flush && (!s4.valid || s4.rnd==0), combinational from registers only.
//  - Completion: s4.valid && s4.rnd==0 -> out_valid=1, out_data=s4.state, out_tag=s4.tag.
//    The slot is freed on the same edge. A new block may be accepted in that same cycle.
//  - Latency: the accepting edge loads s1. out_valid is high in the cycle after the 39th subsequent edge (10 passes x 4 stages - 1).
//  - Throughput: 4 blocks per 40 cycles. Output order equals input order. A slot never overtakes another.
//  - Round count: rnd is 9..0, decremented only on feedback, never wraps. rcon is indexed by rnd+1 (1..10).
//  - flush: all 4 slots are cleared on the edge (s2..s4 are invalidated too). No out_valid on or after that edge for discarded blocks.
//  - rst mid-operation: immediate clear, identical to the reset state. No stale out_valid after release.
//  - Invalid slots propagate with valid=0. With ZERO_IDLE=1 their state/key/tag are 0.
// STRUCTURE
//  - Package aes_inv_pkg:
//      rcon[1:10]
//      NR=10, NSLOT=4
//      slot field widths/offsets
//      inv_sbox function
//      xtime/gmul helpers for InvMixColumns
//  - Sub-module inv_gen_rnd_key (combinational):
//      inputs (rnd_idx[3:0], key_i[127:0]) -> output key_prev[127:0]
//      w[i-4] = w[i] ^ w[i-1] for i = 3..1; w0' = w0 ^ SubWord(RotWord(w3')) ^ rcon.
//  - InvShiftRows, InvSubBytes and InvMixColumns are combinational functions instantiated once each, shared by the ring.
// TESTING
//  - FIPS-197 App.B: ct 3925841d02dc09fbdc118597196a0b32, key10 d014f9a8c9ee2589e13f0cc8b6630ca6, tag 1
//      -> out_valid pulses 40 cycles after the accepting cycle
//      -> pt 3243f6a8885a308d313198a2e0370734, tag 1.
//  - FIPS-197 C.1: ct 69c4e0d86a7b0430d8cdb78070b4c55a, key10 13111d7fe3944a17f307a78b4d2b30c5
//      -> pt 00112233445566778899aabbccddeeff.
//  - 5 back-to-back offers with tags 0..3,0:
//      -> 4 accepted on consecutive cycles, 5th held with in_ready=0 until the 1st completes;
//      -> it is accepted in that same cycle; outputs in tag order 0,1,2,3,0.
//  - flush asserted 20 cycles after 2 acceptances -> no out_valid for the next 60 cycles, busy=0 after the edge, in_ready=1.
//  - rst pulsed mid-flight (asynchronous, between edges):
//      -> out_valid/out_data/busy go 0 immediately;
//      -> a fresh App.B block after release decrypts correctly.
//  - Random ct/key10/tag stream vs reference model, with in_valid toggling randomly
//      -> exact pt/tag match, no drops or duplicates.

Source files
------------

// File: rtl/aes_inv_pkg.sv
// Shared definitions for the AES-128 inverse cipher ring.
// Holds the ring geometry, the slot record carried through each ring
// stage, the forward/inverse S-box tables, GF(2^8) helpers, and the
// three per-stage state transforms (InvShiftRows, InvSubBytes,
// InvMixColumns) plus the word helpers used by the key generator.
// No ports: this file is a package.
package aes_inv_pkg;

   localparam int NR    = 10;   // AES-128 round count
   localparam int NSLOT = 4;    // ring depth = blocks in flight
   localparam int BLK_W = 128;  // state and key width
   localparam int RND_W = 4;    // round counter width (holds 9..0)

   // One ring slot without the caller tag; the tag width is a module
   // parameter, so tags ride in a parallel array next to the ring.
   typedef struct packed {
      logic             valid;
      logic [RND_W-1:0] rnd;
      logic [BLK_W-1:0] state;
      logic [BLK_W-1:0] key;
   } slot_t;

   // Byte x of each table sits at [2047-8*x -: 8].
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [2047:0] INV_SBOX_TBL = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   // Forward S-box: the key schedule runs SubWord even when decrypting.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TBL[2047 - 8*int'(x) -: 8];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return INV_SBOX_TBL[2047 - 8*int'(x) -: 8];
   endfunction

   // Round constant for the key that produced round idx (1..10).
   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit constant (InvMixColumns uses 9, b, d, e only).
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
      logic [7:0] acc;
      logic [7:0] p;
      acc = 8'h00;
      p   = a;
      for (int i = 0; i < 4; i++) begin
         if (m[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // State byte (r + 4c) sits at [127-8*(r+4c) -: 8]; row r rotates right by r.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] res;
      res = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            res[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
         end
      end
      return res;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] res;
      res = '0;
      for (int i = 0; i < 16; i++) begin
         res[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
      end
      return res;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] res;
      logic [7:0]   a0, a1, a2, a3;
      res = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         res[127 - 32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
         res[119 - 32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
         res[111 - 32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
         res[103 - 32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
      end
      return res;
   endfunction

endpackage

// File: rtl/inv_gen_rnd_key.sv
// Reverse AES-128 key-schedule step (combinational).
// Given round key number rnd_idx, returns round key rnd_idx-1.
// Ports:
//   rnd_idx  [3:0]   index of key_i in the schedule (1..10); selects rcon
//   key_i    [127:0] round key rnd_idx, word 0 in [127:96]
//   key_prev [127:0] round key rnd_idx-1
module inv_gen_rnd_key
   import aes_inv_pkg::*;
(
   input  logic [3:0]   rnd_idx,
   input  logic [127:0] key_i,
   output logic [127:0] key_prev
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] p0, p1, p2, p3;

   always_comb begin
      w0 = key_i[127:96];
      w1 = key_i[95:64];
      w2 = key_i[63:32];
      w3 = key_i[31:0];
      // Words 3..1 undo the plain XOR chain; word 0 needs the recovered
      // previous word 3 (p3) to rebuild the SubWord/RotWord term.
      p3 = w3 ^ w2;
      p2 = w2 ^ w1;
      p1 = w1 ^ w0;
      p0 = w0 ^ sub_word(rot_word(p3)) ^ {rcon(rnd_idx), 24'h000000};
      key_prev = {p0, p1, p2, p3};
   end

endmodule

// File: rtl/inv_cipher_pipe.sv
// AES-128 inverse cipher as a four-slot ring pipeline.
// Stages: s1 InvShiftRows, s2 InvSubBytes, s3 AddRoundKey with on-the-fly
// reverse key schedule, s4 InvMixColumns (skipped on the last pass).
// A block makes 10 passes round the ring; up to 4 blocks share it.
// Handshake: a block is taken on a rising edge where in_valid && in_ready.
// in_ready is high when flush is low and the slot arriving at the ring
// entry (s4) is empty or finishing. out_valid is a one-cycle pulse with no
// back-pressure; out_data/out_tag read 0 whenever out_valid is low.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   flush                 drop every in-flight block on the next edge
//   in_valid/in_ready     ciphertext offer / entry slot free
//   in_data, in_key       ciphertext and round-10 key, byte 0 in [127:120]
//   in_tag                caller id, returned with the plaintext
//   out_valid, out_data   plaintext pulse and value
//   out_tag               tag of out_data
//   busy                  any slot occupied
module inv_cipher_pipe
   import aes_inv_pkg::*;
#(
   parameter int TAG_W     = 2,
   parameter bit ZERO_IDLE = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_data,
   input  logic [127:0]     in_key,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   output logic [127:0]     out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   // ring[0]..ring[3] are stages s1..s4; tag_r runs alongside.
   slot_t            ring  [NSLOT];
   logic [TAG_W-1:0] tag_r [NSLOT];

   slot_t            nxt     [NSLOT];
   logic [TAG_W-1:0] nxt_tag [NSLOT];

   logic         feedback;
   logic         accept;
   logic         done;
   logic [127:0] isr_in;
   logic [127:0] isr_out;
   logic [127:0] isb_out;
   logic [127:0] imc_out;
   logic [127:0] ark_key;
   logic [3:0]   ark_idx;

   // Each transform exists once; the entry mux picks which block feeds
   // InvShiftRows.
   assign isr_out = inv_shift_rows(isr_in);
   assign isb_out = inv_sub_bytes(ring[0].state);
   assign imc_out = inv_mix_columns(ring[2].state);

   // s2 holds round key rnd+1; the generator steps it back to round rnd.
   assign ark_idx = ring[1].rnd + 4'd1;

   inv_gen_rnd_key u_key_gen (
      .rnd_idx  (ark_idx),
      .key_i    (ring[1].key),
      .key_prev (ark_key)
   );

   always_comb begin
      feedback = ring[3].valid && (ring[3].rnd != 4'd0);
      done     = ring[3].valid && (ring[3].rnd == 4'd0);
      in_ready = !flush && (!ring[3].valid || (ring[3].rnd == 4'd0));
      accept   = in_valid && in_ready;
      isr_in   = feedback ? ring[3].state : (in_data ^ in_key);

      // Entry: recirculation has priority over a new block, which is why
      // in_ready drops whenever s4 still has rounds to go.
      nxt[0]     = '0;
      nxt_tag[0] = '0;
      if (flush) begin
         nxt[0]     = '0;
         nxt_tag[0] = '0;
      end else if (feedback) begin
         nxt[0].valid = 1'b1;
         nxt[0].rnd   = ring[3].rnd - 4'd1;
         nxt[0].state = isr_out;
         nxt[0].key   = ring[3].key;
         nxt_tag[0]   = tag_r[3];
      end else if (accept) begin
         // The initial AddRoundKey with the round-10 key is folded into
         // the entry path.
         nxt[0].valid = 1'b1;
         nxt[0].rnd   = 4'(NR - 1);
         nxt[0].state = isr_out;
         nxt[0].key   = in_key;
         nxt_tag[0]   = in_tag;
      end

      nxt[1]       = ring[0];
      nxt[1].state = isb_out;
      nxt_tag[1]   = tag_r[0];

      nxt[2]       = ring[1];
      nxt[2].state = ring[1].state ^ ark_key;
      nxt[2].key   = ark_key;
      nxt_tag[2]   = tag_r[1];

      nxt[3]       = ring[2];
      nxt[3].state = (ring[2].rnd != 4'd0) ? imc_out : ring[2].state;
      nxt_tag[3]   = tag_r[2];

      // Empty slots carry no residue of key material when ZERO_IDLE is set.
      if (ZERO_IDLE) begin
         for (int i = 1; i < NSLOT; i++) begin
            if (!nxt[i].valid) begin
               nxt[i]     = '0;
               nxt_tag[i] = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NSLOT; i++) begin
            ring[i]  <= '0;
            tag_r[i] <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < NSLOT; i++) begin
            ring[i]  <= '0;
            tag_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NSLOT; i++) begin
            ring[i]  <= nxt[i];
            tag_r[i] <= nxt_tag[i];
         end
      end
   end

   // A finishing block leaves from s4 straight out; nothing re-enters
   // for it, so its slot is free for a new block on the same edge.
   always_comb begin
      out_valid = done;
      out_data  = done ? ring[3].state : '0;
      out_tag   = done ? tag_r[3] : '0;
      busy      = 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
         busy = busy | ring[i].valid;
      end
   end

endmodule

// File: tb/tb_inv_cipher_pipe.sv
// Testbench for inv_cipher_pipe: FIPS-197 vectors, back-to-back fill,
// flush, asynchronous reset mid-flight, and a random stream whose
// expected plaintexts come from a forward AES-128 model built here.
module tb_inv_cipher_pipe;

   localparam int TAG_W = 2;

   localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [127:0]     in_data;
   logic [127:0]     in_key;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic [127:0]     out_data;
   logic [TAG_W-1:0] out_tag;
   logic             busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] sb [256];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   inv_cipher_pipe #(.TAG_W(TAG_W), .ZERO_IDLE(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_key    (in_key),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   // ---------------- reference model (forward AES-128) ----------------
   function automatic logic [7:0] tb_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = tb_xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d;
      d = {v, v} << n;
      return d[15:8];
   endfunction

   // S-box from first principles: GF(2^8) inverse followed by the affine map.
   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv;
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic aes_encrypt(input logic [127:0] pt, input logic [127:0] key,
                              output logic [127:0] ct, output logic [127:0] k10);
      logic [31:0]  w [44];
      logic [31:0]  t;
      logic [7:0]   rc;
      logic [127:0] st;
      logic [7:0]   b  [16];
      logic [7:0]   nb [16];
      logic [7:0]   a0, a1, a2, a3;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h000000};
            rc = tb_xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      st = pt ^ {w[0], w[1], w[2], w[3]};
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) b[i] = sb[st[127 - 8*i -: 8]];
         for (int rr = 0; rr < 4; rr++) begin
            for (int c = 0; c < 4; c++) nb[rr + 4*c] = b[rr + 4*((c + rr) % 4)];
         end
         if (r != 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = nb[4*c]; a1 = nb[4*c+1]; a2 = nb[4*c+2]; a3 = nb[4*c+3];
               b[4*c]   = tb_gmul(a0, 8'h02) ^ tb_gmul(a1, 8'h03) ^ a2 ^ a3;
               b[4*c+1] = a0 ^ tb_gmul(a1, 8'h02) ^ tb_gmul(a2, 8'h03) ^ a3;
               b[4*c+2] = a0 ^ a1 ^ tb_gmul(a2, 8'h02) ^ tb_gmul(a3, 8'h03);
               b[4*c+3] = tb_gmul(a0, 8'h03) ^ a1 ^ a2 ^ tb_gmul(a3, 8'h02);
            end
         end else begin
            b = nb;
         end
         for (int i = 0; i < 16; i++) st[127 - 8*i -: 8] = b[i];
         st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
      ct  = st;
      k10 = {w[40], w[41], w[42], w[43]};
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      in_valid = 1'b0;
      in_data  = '0;
      in_key   = '0;
      in_tag   = '0;
   endtask

   // Offer one block into an idle ring and wait for its completion pulse.
   // Returns at the negedge where out_valid is seen (or after the bound).
   task automatic run_single(input logic [127:0] ct, input logic [127:0] k,
                             input logic [TAG_W-1:0] tag, output int lat,
                             output logic [127:0] pt, output logic [TAG_W-1:0] tag_o);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = ct;
      in_key   = k;
      in_tag   = tag;
      @(posedge clk);
      @(negedge clk);
      drive_idle();
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      pt    = out_data;
      tag_o = out_tag;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
      checks++; if (out_tag !== 2'd0) begin errors++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_fips_b();
      int lat;
      logic [127:0] pt;
      logic [TAG_W-1:0] tg;
      run_single(B_CT, B_K10, 2'd1, lat, pt, tg);
      checks++; if (lat !== 39) begin errors++; $display("FAIL appb_latency: got %0d expected 39", lat); end
      checks++; if (pt !== B_PT) begin errors++; $display("FAIL appb_pt: got %h expected %h", pt, B_PT); end
      checks++; if (tg !== 2'd1) begin errors++; $display("FAIL appb_tag: got %0d expected 1", tg); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL appb_single_pulse: got %b expected 0", out_valid); end
      checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL appb_data_idle: got %h expected 0", out_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL appb_busy_after: got %b expected 0", busy); end
   endtask

   task automatic test_fips_c1();
      int lat;
      logic [127:0] pt;
      logic [TAG_W-1:0] tg;
      run_single(C_CT, C_K10, 2'd2, lat, pt, tg);
      checks++; if (lat !== 39) begin errors++; $display("FAIL c1_latency: got %0d expected 39", lat); end
      checks++; if (pt !== C_PT) begin errors++; $display("FAIL c1_pt: got %h expected %h", pt, C_PT); end
      checks++; if (tg !== 2'd2) begin errors++; $display("FAIL c1_tag: got %0d expected 2", tg); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [127:0]     cts  [5];
      logic [127:0]     ks   [5];
      logic [127:0]     pts  [5];
      logic [TAG_W-1:0] tags [5];
      int acc_cyc [5];
      int out_cyc [5];
      int exp_acc [5];
      int idx;
      int held;
      int n_out;
      logic [127:0]     exp_q [$];
      logic [TAG_W-1:0] exp_tag_q [$];
      logic [127:0]     e;
      logic [TAG_W-1:0] et;
      exp_acc = '{0, 1, 2, 3, 40};
      for (int i = 0; i < 5; i++) begin
         cts[i]  = (i % 2 == 0) ? B_CT  : C_CT;
         ks[i]   = (i % 2 == 0) ? B_K10 : C_K10;
         pts[i]  = (i % 2 == 0) ? B_PT  : C_PT;
         tags[i] = TAG_W'(i % 4);
         acc_cyc[i] = -1;
         out_cyc[i] = -1;
      end
      idx = 0; held = 0; n_out = 0;
      for (int c = 0; c < 120; c++) begin
         @(negedge clk);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL b2b_unexpected_out: got %h tag %0d expected no output", out_data, out_tag);
            end else begin
               e = exp_q.pop_front();
               et = exp_tag_q.pop_front();
               checks++; if (out_data !== e || out_tag !== et) begin errors++; $display("FAIL b2b_out: got %h tag %0d expected %h tag %0d", out_data, out_tag, e, et); end
               if (n_out < 5) out_cyc[n_out] = c;
               n_out++;
            end
         end
         if (idx < 5) begin
            in_valid = 1'b1;
            in_data  = cts[idx];
            in_key   = ks[idx];
            in_tag   = tags[idx];
            if (in_ready) begin
               acc_cyc[idx] = c;
               exp_q.push_back(pts[idx]);
               exp_tag_q.push_back(tags[idx]);
               idx++;
            end else begin
               held++;
            end
         end else begin
            drive_idle();
         end
      end
      drive_idle();
      for (int i = 0; i < 5; i++) begin
         checks++; if (acc_cyc[i] !== exp_acc[i]) begin errors++; $display("FAIL b2b_accept_cycle[%0d]: got %0d expected %0d", i, acc_cyc[i], exp_acc[i]); end
      end
      checks++; if (held !== 36) begin errors++; $display("FAIL b2b_held_cycles: got %0d expected 36", held); end
      checks++; if (n_out !== 5) begin errors++; $display("FAIL b2b_out_count: got %0d expected 5", n_out); end
      checks++; if (out_cyc[0] !== 40 || out_cyc[4] !== 80) begin errors++; $display("FAIL b2b_out_cycles: got %0d/%0d expected 40/80", out_cyc[0], out_cyc[4]); end
   endtask

   task automatic test_flush();
      int n_valid;
      @(negedge clk);
      in_valid = 1'b1; in_data = B_CT; in_key = B_K10; in_tag = 2'd1;
      @(negedge clk);
      in_valid = 1'b1; in_data = C_CT; in_key = C_K10; in_tag = 2'd2;
      @(negedge clk);
      drive_idle();
      repeat (19) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before: got %b expected 1", busy); end
      flush = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready_during: got %b expected 0", in_ready); end
      @(negedge clk);
      flush = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_after: got %b expected 0", busy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready_after: got %b expected 1", in_ready); end
      n_valid = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (out_valid) n_valid++;
      end
      checks++; if (n_valid !== 0) begin errors++; $display("FAIL flush_no_output: got %0d pulses expected 0", n_valid); end
   endtask

   task automatic test_rst_mid();
      int lat;
      logic [127:0] pt;
      logic [TAG_W-1:0] tg;
      @(negedge clk);
      in_valid = 1'b1; in_data = C_CT; in_key = C_K10; in_tag = 2'd3;
      @(posedge clk);
      @(negedge clk);
      drive_idle();
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b expected 1", out_valid); end
      #1 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL rst_async_out_data: got %h expected 0", out_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_async_in_ready: got %b expected 1", in_ready); end
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_stale_valid: got %b expected 0", out_valid); end
      run_single(B_CT, B_K10, 2'd1, lat, pt, tg);
      checks++; if (lat !== 39) begin errors++; $display("FAIL rst_fresh_latency: got %0d expected 39", lat); end
      checks++; if (pt !== B_PT) begin errors++; $display("FAIL rst_fresh_pt: got %h expected %h", pt, B_PT); end
      checks++; if (tg !== 2'd1) begin errors++; $display("FAIL rst_fresh_tag: got %0d expected 1", tg); end
      @(negedge clk);
   endtask

   task automatic test_random();
      localparam int N = 16;
      logic [127:0]     pt_a  [N];
      logic [127:0]     ct_a  [N];
      logic [127:0]     k10_a [N];
      logic [TAG_W-1:0] tag_a [N];
      logic [127:0]     k0;
      logic [127:0]     exp_q [$];
      logic [TAG_W-1:0] exp_tag_q [$];
      logic [127:0]     e;
      logic [TAG_W-1:0] et;
      int sent;
      int got;
      int extra;
      for (int i = 0; i < N; i++) begin
         pt_a[i]  = {$urandom, $urandom, $urandom, $urandom};
         k0       = {$urandom, $urandom, $urandom, $urandom};
         tag_a[i] = TAG_W'($urandom_range(0, 3));
         aes_encrypt(pt_a[i], k0, ct_a[i], k10_a[i]);
      end
      sent = 0; got = 0; extra = 0;
      for (int c = 0; c < 3000 && got < N + extra; c++) begin
         @(negedge clk);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               checks++; errors++; extra++;
               $display("FAIL rand_unexpected_out: got %h tag %0d expected no output", out_data, out_tag);
            end else begin
               e = exp_q.pop_front();
               et = exp_tag_q.pop_front();
               checks++; if (out_data !== e) begin errors++; $display("FAIL rand_pt[%0d]: got %h expected %h", got, out_data, e); end
               checks++; if (out_tag !== et) begin errors++; $display("FAIL rand_tag[%0d]: got %0d expected %0d", got, out_tag, et); end
               got++;
            end
         end
         if (sent < N && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b1;
            in_data  = ct_a[sent];
            in_key   = k10_a[sent];
            in_tag   = tag_a[sent];
            if (in_ready) begin
               exp_q.push_back(pt_a[sent]);
               exp_tag_q.push_back(tag_a[sent]);
               sent++;
            end
         end else begin
            drive_idle();
         end
      end
      drive_idle();
      extra = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      checks++; if (sent !== N) begin errors++; $display("FAIL rand_sent: got %0d expected %0d", sent, N); end
      checks++; if (got !== N) begin errors++; $display("FAIL rand_received: got %0d expected %0d", got, N); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rand_queue_left: got %0d expected 0", exp_q.size()); end
      checks++; if (extra !== 0) begin errors++; $display("FAIL rand_duplicates: got %0d expected 0", extra); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst   = 1'b0;
      flush = 1'b0;
      drive_idle();
      build_sbox();
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_fips_b();
      test_fips_c1();
      test_back_to_back();
      test_flush();
      test_rst_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
